// File: rtl/branch_compare_unit_if.sv
// Operand/decision bus for the RV32I branch comparator.
// The DUT takes the slave modport and the driving side takes the master modport.
interface branch_compare_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            BrUn;
  logic            in_valid;
  logic [2:0]      funct3;
  logic            Eq;
  logic            Lt;
  logic            out_valid;
  logic            br_taken;
  logic            br_illegal;

  // in_valid qualifies one branch per cycle. There is no ready signal:
  // every valid input is accepted, and its result appears one cycle later
  // together with out_valid.
  modport master (
    output A, B, BrUn, in_valid, funct3,
    input  Eq, Lt, out_valid, br_taken, br_illegal
  );

  modport slave (
    input  A, B, BrUn, in_valid, funct3,
    output Eq, Lt, out_valid, br_taken, br_illegal
  );
endinterface

// File: rtl/branch_compare_unit.sv
// RV32I branch comparator: combinational Eq/Lt plus a registered branch decision.
// Define BRCMP_STATS_EN to add the taken_cnt/resolved_cnt statistics counters.
module branch_compare_unit #(
  parameter int XLEN = 32  // must be at least 2
) (
  input  logic                clk,
  input  logic                rst,
  branch_compare_unit_if.slave bus
`ifdef BRCMP_STATS_EN
  ,
  output logic [31:0]         taken_cnt,
  output logic [31:0]         resolved_cnt
`endif
);

  logic            eqRaw;
  logic            ltUnsigned;
  logic            ltSigned;
  logic [XLEN-1:0] aFlip;
  logic [XLEN-1:0] bFlip;
  logic            decision;
  logic            illegal;

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so a signed compare needs no subtraction and cannot overflow.
  always_comb begin
    aFlip      = {~bus.A[XLEN-1], bus.A[XLEN-2:0]};
    bFlip      = {~bus.B[XLEN-1], bus.B[XLEN-2:0]};
    eqRaw      = (bus.A == bus.B);
    ltUnsigned = (bus.A < bus.B);
    ltSigned   = (aFlip < bFlip);
  end

  assign bus.Eq = eqRaw;
  assign bus.Lt = bus.BrUn ? ltUnsigned : ltSigned;

  // funct3 picks its own signedness; BrUn only steers the Lt flag.
  always_comb begin
    decision = 1'b0;
    illegal  = 1'b0;
    unique case (bus.funct3)
      3'b000: decision = eqRaw;
      3'b001: decision = ~eqRaw;
      3'b100: decision = ltSigned;
      3'b101: decision = ~ltSigned;
      3'b110: decision = ltUnsigned;
      3'b111: decision = ~ltUnsigned;
      3'b010,
      3'b011: illegal  = 1'b1;
      default: decision = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.br_taken   <= 1'b0;
      bus.br_illegal <= 1'b0;
    end else begin
      bus.out_valid  <= bus.in_valid;
      bus.br_taken   <= bus.in_valid & decision;
      bus.br_illegal <= bus.in_valid & illegal;
    end
  end

`ifdef BRCMP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_cnt    <= 32'd0;
      resolved_cnt <= 32'd0;
    end else if (bus.in_valid && !illegal) begin
      resolved_cnt <= resolved_cnt + 32'd1;
      if (decision) begin
        taken_cnt <= taken_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_compare_unit.sv
// Self-checking bench for branch_compare_unit: directed test-plan steps,
// async reset, then randomized branches against a behavioural model.
module tb_branch_compare_unit;
  localparam int W = 32;

  logic clk;
  logic rst;

  branch_compare_unit_if #(.XLEN(W)) bus ();

`ifdef BRCMP_STATS_EN
  logic [31:0] taken_cnt;
  logic [31:0] resolved_cnt;
`endif

  branch_compare_unit #(.XLEN(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef BRCMP_STATS_EN
    ,
    .taken_cnt    (taken_cnt),
    .resolved_cnt (resolved_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];
  int unsigned expTaken    = 0;
  int unsigned expResolved = 0;

  // behavioural reference
  function automatic logic modelLt(input logic [W-1:0] a, input logic [W-1:0] b, input logic un);
    if (un) return (a < b);
    return ($signed(a) < $signed(b));
  endfunction

  function automatic logic modelLegal(input logic [2:0] f3);
    return !(f3 == 3'b010 || f3 == 3'b011);
  endfunction

  function automatic logic modelTaken(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f3);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: apply one input at the falling edge, check the flags, then the
  // registered result after the next rising edge.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic un,
                      input logic v, input logic [2:0] f3);
    logic [2:0] e;
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.BrUn     = un;
    bus.in_valid = v;
    bus.funct3   = f3;
    exp_q.push_back({v, v & modelTaken(a, b, f3), v & !modelLegal(f3)});
    if (v && modelLegal(f3)) begin
      expResolved++;
      if (modelTaken(a, b, f3)) expTaken++;
    end
    #1;
    check("Eq", {31'd0, bus.Eq}, {31'd0, a == b});
    check("Lt", {31'd0, bus.Lt}, {31'd0, modelLt(a, b, un)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("out_valid",  {31'd0, bus.out_valid},  {31'd0, e[2]});
    check("br_taken",   {31'd0, bus.br_taken},   {31'd0, e[1]});
    check("br_illegal", {31'd0, bus.br_illegal}, {31'd0, e[0]});
`ifdef BRCMP_STATS_EN
    check("taken_cnt",    taken_cnt,    expTaken);
    check("resolved_cnt", resolved_cnt, expResolved);
`endif
  endtask

  task automatic checkRegsZero(input string tag);
    check({tag, "_out_valid"},  {31'd0, bus.out_valid},  32'd0);
    check({tag, "_br_taken"},   {31'd0, bus.br_taken},   32'd0);
    check({tag, "_br_illegal"}, {31'd0, bus.br_illegal}, 32'd0);
`ifdef BRCMP_STATS_EN
    check({tag, "_taken_cnt"},    taken_cnt,    32'd0);
    check({tag, "_resolved_cnt"}, resolved_cnt, 32'd0);
`endif
  endtask

  logic [2:0] f3Tab[6];
  logic       takTab[6];

  initial begin
    f3Tab  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    takTab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // reset state
    rst          = 1'b1;
    bus.A        = '0;
    bus.B        = '0;
    bus.BrUn     = 1'b0;
    bus.in_valid = 1'b0;
    bus.funct3   = 3'b000;
    #1;
    checkRegsZero("reset");
    repeat (2) @(posedge clk);
    #1;
    checkRegsZero("reset_held");
    @(negedge clk);
    rst = 1'b0;

    // comparator test-plan points (in_valid low)
    step(-32'sd7,  -32'sd11, 1'b1, 1'b0, 3'b000);
    check("plan_lt_unsigned_m7_m11", {31'd0, bus.Lt}, 32'd0);
    step(-32'sd7,  -32'sd11, 1'b0, 1'b0, 3'b000);
    step(-32'sd7,  -32'sd7,  1'b0, 1'b0, 3'b000);
    step(-32'sd7,  -32'sd7,  1'b1, 1'b0, 3'b000);
    step(32'd0,    32'd0,    1'b1, 1'b0, 3'b000);
    step(32'd0,    32'd0,    1'b0, 1'b0, 3'b000);
    step(-32'sd15, -32'sd16, 1'b1, 1'b0, 3'b000);
    step(-32'sd1,  32'd1,    1'b0, 1'b0, 3'b000);
    check("plan_lt_signed_m1_1", {31'd0, bus.Lt}, 32'd1);
    step(-32'sd1,  32'd1,    1'b1, 1'b0, 3'b000);
    step(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 3'b000);
    step(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 3'b000);

    // each legal funct3 with A=-1, B=1
    for (int i = 0; i < 6; i++) begin
      step(-32'sd1, 32'd1, 1'b0, 1'b1, f3Tab[i]);
      check("plan_taken_table", {31'd0, bus.br_taken}, {31'd0, takTab[i]});
    end
    step(-32'sd1, 32'd1, 1'b0, 1'b1, 3'b010);
    step(-32'sd1, 32'd1, 1'b0, 1'b1, 3'b011);
    step(-32'sd1, 32'd1, 1'b0, 1'b0, 3'b000);

    // async reset between edges, with a taken branch in the output register
    step(32'd5, 32'd5, 1'b0, 1'b1, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    checkRegsZero("async_rst");
    bus.A = 32'd3;
    bus.B = 32'd3;
    #1;
    check("rst_Eq_tracks", {31'd0, bus.Eq}, 32'd1);
    @(posedge clk);
    #1;
    checkRegsZero("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    expTaken    = 0;
    expResolved = 0;

    // 3 taken + 1 not-taken legal branches
    step(32'd1, 32'd1, 1'b0, 1'b1, 3'b000);
    step(32'd1, 32'd2, 1'b0, 1'b1, 3'b001);
    step(32'd1, 32'd2, 1'b0, 1'b1, 3'b110);
    step(32'd1, 32'd2, 1'b0, 1'b1, 3'b111);
`ifdef BRCMP_STATS_EN
    check("plan_taken_cnt_3",    taken_cnt,    32'd3);
    check("plan_resolved_cnt_4", resolved_cnt, 32'd4);
`endif

    // randomized branches
    for (int n = 0; n < 300; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (32'd1 << $urandom_range(0, 31));
        default: b = $urandom;
      endcase
      step(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
